// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Optional busy scoreboard is enabled with WB_SCOREBOARD_EN.
package wb_port_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int ENTRY_W = REG_AW + REG_DW;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'h0;
    localparam logic [REG_DW-1:0] ZERO_WORD = 32'h0;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between pipeline/long unit/issue stage and the arbiter.
// master = surrounding core side, slave = arbiter side.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic      pipe_wreg;
    reg_addr_t pipe_waddr;
    reg_data_t pipe_wdata;
    logic      pipe_stall;
    logic      lu_valid;
    logic      lu_ready;
    reg_addr_t lu_waddr;
    reg_data_t lu_wdata;
    logic      wreg;
    reg_addr_t waddr;
    reg_data_t wdata;
    logic      sb_set;
    reg_addr_t sb_addr;
    reg_addr_t raddr1;
    reg_addr_t raddr2;
    logic      hazard1;
    logic      hazard2;

    modport master (
        output pipe_wreg, pipe_waddr, pipe_wdata,
        input  pipe_stall,
        output lu_valid, lu_waddr, lu_wdata,
        input  lu_ready,
        input  wreg, waddr, wdata,
        output sb_set, sb_addr, raddr1, raddr2,
        input  hazard1, hazard2
    );

    modport slave (
        input  pipe_wreg, pipe_waddr, pipe_wdata,
        output pipe_stall,
        input  lu_valid, lu_waddr, lu_wdata,
        output lu_ready,
        output wreg, waddr, wdata,
        input  sb_set, sb_addr, raddr1, raddr2,
        output hazard1, hazard2
    );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-unit results {addr, data}.
// No fall-through: a pushed entry appears at dout the following cycle.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = din;
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline first, long-unit FIFO drains idle slots.
// Define WB_SCOREBOARD_EN to add the busy scoreboard and read-hazard outputs.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int LU_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic resetn,
    wb_port_arbiter_if.slave bus
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic       rdy_q, rdy_d;
    logic [3:0] starve_q, starve_d;
    logic       fifo_full, fifo_empty;
    logic       fifo_push, fifo_gnt;
    logic       pipe_eff, starve_hit;
    logic [ENTRY_W-1:0] fifo_dout;
    wb_entry_t  head;

    assign head      = wb_entry_t'(fifo_dout);
    assign pipe_eff  = bus.pipe_wreg && (bus.pipe_waddr != REG_ZERO);
    assign starve_hit = !fifo_empty && (starve_q == SMAX);

    // Zero-address results complete the handshake but are never stored.
    assign bus.lu_ready = rdy_q && !fifo_full;
    assign fifo_push = bus.lu_valid && bus.lu_ready &&
                       (bus.lu_waddr != REG_ZERO);

    wb_fifo #(
        .DEPTH (LU_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .pop    (fifo_gnt),
        .din    ({bus.lu_waddr, bus.lu_wdata}),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        bus.wreg       = 1'b0;
        bus.waddr      = REG_ZERO;
        bus.wdata      = ZERO_WORD;
        bus.pipe_stall = 1'b0;
        fifo_gnt       = 1'b0;
        if (starve_hit) begin
            fifo_gnt       = 1'b1;
            bus.pipe_stall = 1'b1;
        end else if (pipe_eff) begin
            bus.wreg  = 1'b1;
            bus.waddr = bus.pipe_waddr;
            bus.wdata = bus.pipe_wdata;
        end else if (!fifo_empty) begin
            fifo_gnt = 1'b1;
        end
        if (fifo_gnt) begin
            bus.wreg  = 1'b1;
            bus.waddr = head.addr;
            bus.wdata = head.data;
        end
    end

    always_comb begin
        rdy_d    = 1'b1;
        starve_d = starve_q + 4'd1;
        if (fifo_empty || fifo_gnt) starve_d = 4'd0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdy_q    <= 1'b0;
            starve_q <= 4'd0;
        end else begin
            rdy_q    <= rdy_d;
            starve_q <= starve_d;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // Set after clear so a same-cycle redispatch keeps the bit busy.
    always_comb begin
        busy_d = busy_q;
        if (fifo_gnt) busy_d[head.addr] = 1'b0;
        if (bus.sb_set && (bus.sb_addr != REG_ZERO)) begin
            busy_d[bus.sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign bus.hazard1 = busy_q[bus.raddr1] &&
                         (bus.raddr1 != REG_ZERO) &&
                         !(fifo_gnt && (head.addr == bus.raddr1));
    assign bus.hazard2 = busy_q[bus.raddr2] &&
                         (bus.raddr2 != REG_ZERO) &&
                         !(fifo_gnt && (head.addr == bus.raddr2));
`else
    logic unused_sb;
    assign unused_sb = ^{bus.sb_set, bus.sb_addr, bus.raddr1, bus.raddr2};
    assign bus.hazard1 = 1'b0;
    assign bus.hazard2 = 1'b0;
`endif

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register file's single write port between the in-order pipeline writeback and a long-latency unit (divider / load-miss return) that finishes out of order. Pipeline writes have priority. Long-unit results are buffered in a small FIFO and drained into idle write slots, with a starvation guard. An optional scoreboard tracks registers with long-unit writes still outstanding and reports read hazards to the issue stage.

## Interface
Parameters:
- LU_DEPTH, 2: long-unit FIFO entries; power of two, ≥2.
- STARVE_MAX, 4: cycles a non-empty FIFO head may wait before the pipeline is stalled; 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- pipe_wreg  in  1  pipeline writeback request (`WriteEnable`).
- pipe_waddr  in  5  pipeline destination register.
- pipe_wdata  in  32  pipeline result.
- pipe_stall  out  1  pipeline must hold its writeback this cycle.
- lu_valid  in  1  long-unit result valid.
- lu_ready  out  1  FIFO can accept a result.
- lu_waddr  in  5  long-unit destination register.
- lu_wdata  in  32  long-unit result.
- wreg  out  1  register file write enable.
- waddr  out  5  register file write address.
- wdata  out  32  register file write data.
- sb_set  in  1  issue stage dispatches a long-unit op.
- sb_addr  in  5  destination register of that op.
- raddr1, raddr2  in  5  issue-stage read addresses.
- hazard1, hazard2  out  1  the corresponding read address has a pending long-unit write.

## Operation
**Effective pipeline write.** pipe_wreg=1 and pipe_waddr≠0.

**Long-unit enqueue.**
- A result is accepted when lu_valid && lu_ready.
- lu_ready = FIFO not full. Reset forces lu_ready=0.
- A result with lu_waddr=0 is dropped and not enqueued. It still completes the handshake.

**Grant.** Evaluated combinationally each cycle, in this order:
- FIFO non-empty and starve_cnt == STARVE_MAX: grant FIFO head, pipe_stall=1.
- Else, effective pipeline write: grant pipeline.
- Else, FIFO non-empty: grant FIFO head.
- Else: wreg=0, waddr=0, wdata=0.

**Starvation counter.**
- starve_cnt counts consecutive cycles in which the FIFO is non-empty and the head is not granted.
- It clears on any FIFO grant and whenever the FIFO is empty.

**Stall contract.** While pipe_stall=1, the pipeline holds pipe_wreg/pipe_waddr/pipe_wdata stable into the next cycle. The held write is granted in that next cycle because the counter has just cleared.

**Outputs.** wreg/waddr/wdata drive the register file directly. Its same-cycle read bypass makes a committed value visible to readers in the commit cycle.

**FIFO behaviour.**
- Pop on FIFO grant. Push and pop may occur in the same cycle.
- A push into a full FIFO cannot occur (lu_ready=0).
- There is no fall-through: an entry pushed at edge N is grantable from cycle N+1.

**Ordering.** Software and the scoreboard guarantee no WAW between the pipeline and FIFO entries to the same register. The arbiter does not reorder FIFO entries.

## Timing
- Pipeline write: zero added latency (combinational path to the write port).
- Long unit: minimum 1 cycle from accept to commit. Worst case under continuous pipeline traffic is STARVE_MAX+1 cycles for the head entry.
- Reset values: wreg=0, waddr=0, wdata=0, pipe_stall=0, lu_ready=0, hazard1/2=0, starve_cnt=0, FIFO empty, busy=0.
- Reset mid-operation: FIFO contents and pending scoreboard bits are discarded immediately, with no commit.

## Configuration
WB_SCOREBOARD_EN:
- **Defined:** 32-bit busy vector.
  - sb_set with sb_addr≠0 sets busy[sb_addr] at the edge.
  - A FIFO grant clears busy[waddr] at the edge.
  - Simultaneous set and clear of the same bit: set wins.
  - hazardN = busy[raddrN] && raddrN≠0 && !(FIFO grant this cycle && waddr==raddrN). The last term reflects the register file bypass.
  - busy[0] is never set.
- **Not defined:** hazard1/hazard2 tied 0, sb_set/sb_addr ignored, no busy storage.

## Structure
- Shared header define.v holds `WriteEnable`, `RstEnable`, `ZeroWord` (existing) plus new constants:
  - `RegAddrBus` (4:0)
  - `RegBus` (31:0)
  - `RegZero` (5'h0)
- One sub-module, wb_fifo: parameterised depth, 37-bit entries {addr, data}, push/pop/full/empty, same async reset.

## Test plan
- **Reset.** Drive resetn=0 with lu_valid=1 → lu_ready=0, wreg=0, hazard1=0. Release → lu_ready=1 at the next cycle.
- **Idle-port drain.** Pipeline idle; push lu {5'd7, 32'hDEAD_BEEF} at edge N → wreg=1, waddr=7, wdata=32'hDEAD_BEEF in cycle N+1, FIFO empty after.
- **Pipeline priority and starvation.** Continuous effective pipeline writes to r3; one FIFO entry for r9 → pipeline granted 4 cycles. Cycle 5: pipe_stall=1, write r9. Cycle 6: held r3 write granted.
- **Full FIFO.** Push 2 entries with the pipeline saturating → lu_ready=0. Lu_valid held high is not accepted until the first pop.
- **$0 handling.** pipe_waddr=0 with pipe_wreg=1 and FIFO non-empty → FIFO head granted. lu_waddr=0 → handshake completes, nothing enqueued.
- **Scoreboard (macro on).** sb_set r5 → hazard1=1 for raddr1=5. Lu result r5 granted in cycle K → hazard1=0 in cycle K, busy clear after. Same-cycle sb_set r5 with the commit of r5 → busy stays 1.
